tach_counter_multi: RTL

Multi-channel tachometer front end. It measures the pulse rate of NUM_CH encoder/hall-sensor inputs over a common fixed gate window and publishes one count per channel per window. Each channel has a metastability synchroniser, a glitch filter, a selectable counted edge, a saturating counter and status flags. The block sits between the motor sensor pins and the processor-readable speed registers of the closed-loop controller.

---
 rtl/tach_counter_multi.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tach_counter_multi.sv
`timescale 1ns/1ps
// tach_counter_multi
// Multi-channel tachometer front end. Each channel synchronises its sensor
// input, rejects glitches shorter than FILT_CYCLES clocks, detects the
// selected edge(s) and counts them with saturation over a gate window shared
// by all channels. At the end of every window the counts are published
// together with a one-cycle valid strobe, per-channel stall flags and sticky
// overflow flags.
module tach_counter_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 100000000,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int EDGE_MODE   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_flags,
    input  logic [NUM_CH-1:0]       tach_in,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic                    count_valid,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH-1:0]       stalled
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int RUN_W  = $clog2(FILT_CYCLES + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Edge selection: 0 = rising, 1 = falling, 2 = both.
    localparam bit COUNT_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam bit COUNT_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    // Input front end state
    logic [SYNC_STAGES-1:0] sync_q   [NUM_CH];
    logic [RUN_W-1:0]       run_q    [NUM_CH];
    logic [NUM_CH-1:0]      filt_q;
    logic [NUM_CH-1:0]      filt_d_q;

    // Counting and result state
    logic [CNT_W-1:0]       cnt_q    [NUM_CH];
    logic [CNT_W-1:0]       cnt_next [NUM_CH];
    logic [CNT_W-1:0]       result_q [NUM_CH];
    logic [NUM_CH-1:0]      overflow_q;
    logic [NUM_CH-1:0]      stalled_q;
    logic [GATE_W-1:0]      gate_q;
    logic                   valid_q;

    // Per-channel combinational helpers
    logic [NUM_CH-1:0]      sync_lvl;
    logic [NUM_CH-1:0]      edge_hit;
    logic [NUM_CH-1:0]      sat_hit;
    logic                   tc;

    // Terminal cycle of the gate window; never occurs while disabled.
    assign tc = enable && (gate_q == GATE_LAST);

    // Edge detection and the saturating next count for every channel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        sync_lvl = '0;
        edge_hit = '0;
        sat_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_next[i] = cnt_q[i];
            sync_lvl[i] = sync_q[i][SYNC_STAGES-1];
            edge_hit[i] = (COUNT_RISE && filt_q[i] && !filt_d_q[i]) ||
                          (COUNT_FALL && !filt_q[i] && filt_d_q[i]);
            sat_hit[i]  = enable && edge_hit[i] && (cnt_q[i] == CNT_MAX);
            if (edge_hit[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_next[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser chain, glitch filter and the delayed filtered level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: these per-channel arrays are ordinary flops rather than RAM, so clearing every element on reset is intended.
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= '0;
                run_q[i]  <= '0;
            end
            filt_q   <= '0;
            filt_d_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            filt_d_q <= filt_q;
            for (int i = 0; i < NUM_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], tach_in[i]};
                if (sync_lvl[i] == filt_q[i]) begin
                    run_q[i] <= '0;
                end else if (run_q[i] == RUN_LAST) begin
                    filt_q[i] <= sync_lvl[i];
                    run_q[i]  <= '0;
                end else begin
                    run_q[i] <= run_q[i] + RUN_W'(1);
                end
            end
        end
    end

    // Edge counters, window results and the status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                result_q[i] <= '0;
            end
            overflow_q <= '0;
            stalled_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!enable) begin
                    cnt_q[i] <= '0;
                end else if (tc) begin
                    // An edge on the terminal cycle closes into this window.
                    cnt_q[i]     <= '0;
                    result_q[i]  <= cnt_next[i];
                    stalled_q[i] <= (cnt_next[i] == '0);
                end else begin
                    cnt_q[i] <= cnt_next[i];
                end

                // A saturation event in the same cycle beats a clear request.
                if (sat_hit[i]) begin
                    overflow_q[i] <= 1'b1;
                end else if (clear_flags) begin
                    overflow_q[i] <= 1'b0;
                end
            end
        end
    end

    // Shared gate counter and the registered end-of-window strobe.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gate_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= tc;
            if (!enable || tc) begin
                gate_q <= '0;
            end else begin
                gate_q <= gate_q + GATE_W'(1);
            end
        end
    end

    // Pack the per-channel results onto the flat output bus.
    always_comb begin
        count_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            count_out[i*CNT_W +: CNT_W] = result_q[i];
        end
    end

    assign count_valid = valid_q;
    assign overflow    = overflow_q;
    assign stalled     = stalled_q;

endmodule
